// File: rtl/store_bank_pkg.sv
// Shared definitions for the store bank: clear-all state encoding, the
// default home-simulation geometry and an elaboration-time clog2 helper.
package store_bank_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam int HOME_WIDTH = 8;
    localparam int HOME_DEPTH = 4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/store_bank_scan_divider.sv
// Modulo-DIV tick counter: tick_o is high during the enabled cycle whose
// closing edge wraps the counter back to zero.
module scan_divider
    import store_bank_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clock,
    input  logic resetn,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (clog2(DIV) < 1) ? 1 : clog2(DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wrap_s;

    // Next count: hold when disabled, wrap at DIV-1.
    always_comb begin
        wrap_s = (cnt_q == CW'(DIV - 1));
        if (!en_i) begin
            cnt_d = cnt_q;
        end else if (wrap_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign tick_o = en_i & wrap_s;

    // Counter register.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/store_bank.sv
// DEPTH x WIDTH store with valid flags, registered read port, sequenced
// clear-all and a round-robin scan port for the display driver.
module store_bank
    import store_bank_pkg::*;
#(
    parameter  int WIDTH    = HOME_WIDTH,
    parameter  int DEPTH    = HOME_DEPTH,
    parameter  int SCAN_DIV = 4,
    localparam int ADDR_W   = clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              clear_all,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              scan_en,
    output logic [ADDR_W-1:0] scan_addr,
    output logic [WIDTH-1:0]  scan_data,
    output logic              scan_valid,
    output logic              busy,
    output logic [ADDR_W:0]   count
);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
    logic [WIDTH-1:0]  rd_data_q, scan_data_q;
    logic              rd_valid_q, scan_valid_q, busy_q;
    logic              tick_s;
    state_e            state_q;

    scan_divider #(.DIV(SCAN_DIV)) u_div (
        .clock  (clock),
        .resetn (resetn),
        .en_i   (scan_en),
        .tick_o (tick_s)
    );

    // Storage next state; clear beats write on the same slot, clear_all beats both.
    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        if (state_q == CLEAR) begin
            mem_d[idx_q]   = '0;
            valid_d[idx_q] = 1'b0;
        end else if (!clear_all) begin
            if (wr_en && !(clr_en && (clr_addr == wr_addr))) begin
                mem_d[wr_addr]   = wr_data;
                valid_d[wr_addr] = 1'b1;
            end else begin
                valid_d = valid_d;
            end
            if (clr_en) begin
                mem_d[clr_addr]   = '0;
                valid_d[clr_addr] = 1'b0;
            end else begin
                valid_d = valid_d;
            end
        end else begin
            valid_d = valid_q;
        end
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + (ADDR_W + 1)'(valid_d[i]);
        end
        scan_addr_d = tick_s ? (scan_addr_q + ADDR_W'(1)) : scan_addr_q;
    end

    // Storage, clear-all FSM and all registered outputs.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            valid_q      <= '0;
            count_q      <= '0;
            idx_q        <= '0;
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            scan_addr_q  <= '0;
            scan_data_q  <= '0;
            scan_valid_q <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            valid_q      <= valid_d;
            count_q      <= count_d;
            rd_data_q    <= mem_q[rd_addr];
            rd_valid_q   <= valid_q[rd_addr];
            scan_addr_q  <= scan_addr_d;
            scan_data_q  <= mem_q[scan_addr_d];
            scan_valid_q <= valid_q[scan_addr_d];
            case (state_q)
                IDLE: begin
                    if (clear_all) begin
                        state_q <= CLEAR;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (idx_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q   <= idx_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign scan_addr  = scan_addr_q;
    assign scan_data  = scan_data_q;
    assign scan_valid = scan_valid_q;
    assign busy       = busy_q;
    assign count      = count_q;

endmodule
